// File: rtl/fetch_queue.sv
// fetch_queue: circular-buffer instruction queue between fetch and decode.
// Each entry carries {instr, pc, pc_plus4}. A redirect (flush) empties the
// queue on the next edge. The outputs are a mux of registered storage
// only, so an empty queue shows a NOP and nothing is bypassed.
module fetch_queue #(
  parameter int WIDTH         = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int DEPTH         = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_instr,
  input  logic [ADDRESS_WIDTH-1:0]   in_pc,
  input  logic [ADDRESS_WIDTH-1:0]   in_pc_plus4,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_instr,
  output logic [ADDRESS_WIDTH-1:0]   out_pc,
  output logic [ADDRESS_WIDTH-1:0]   out_pc_plus4,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic [WIDTH-1:0]         instr_mem [DEPTH];
  logic [ADDRESS_WIDTH-1:0] pc_mem    [DEPTH];
  logic [ADDRESS_WIDTH-1:0] pc4_mem   [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic push;
  logic pop;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign count     = count_q;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // Next-state for pointers and occupancy; flush overrides any handshake.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so the natural PW-bit overflow is the wrap.
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  // Pointer and occupancy registers, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; no reset needed since stale entries are never visible.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      instr_mem[wr_ptr_q] <= in_instr;
      pc_mem[wr_ptr_q]    <= in_pc;
      pc4_mem[wr_ptr_q]   <= in_pc_plus4;
    end
  end

  // Head view: NOP and zero PCs when empty, otherwise the entry at rd_ptr.
  always_comb begin
    out_instr    = WIDTH'(NOP_INSTR);
    out_pc       = '0;
    out_pc_plus4 = '0;
    if (!empty) begin
      out_instr    = instr_mem[rd_ptr_q];
      out_pc       = pc_mem[rd_ptr_q];
      out_pc_plus4 = pc4_mem[rd_ptr_q];
    end
  end

endmodule
